// File: rtl/neuron_mac_n.sv
// Sequential fixed-point neuron: one multiply-accumulate per cycle over NUM_INPUTS inputs,
// then a selectable activation (hard sigmoid / ReLU / identity) with saturating arithmetic.
module neuron_mac_n #(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH,
    parameter int AW         = $clog2(NUM_INPUTS+1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             En,
    input  logic                             Run,
    input  logic [1:0]                       Mode,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] X,
    input  logic                             w_we,
    input  logic [AW-1:0]                    w_addr,
    input  logic [DATA_WIDTH-1:0]            w_data,
    output logic [DATA_WIDTH-1:0]            Y,
    output logic                             Ready,
    output logic                             Busy
);

    localparam int PW = 2*DATA_WIDTH;
    localparam int SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
    localparam int EW = ACC_WIDTH + 1;

    localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0] ONE  = EW'(1) <<< FRAC_BITS;
    localparam logic signed [EW-1:0] HALF = ONE >>> 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_ACT, S_RESULT} state_t;

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  w_q  [0:NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0]  xr_q [0:NUM_INPUTS-1];
    logic [1:0]                    mode_q;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [AW-1:0]                 idx_q;
    logic [DATA_WIDTH-1:0]         yb_q, act_d;
    logic [DATA_WIDTH-1:0]         y_q;
    logic                          ready_q;

    logic signed [PW-1:0]          prod;
    logic signed [SW-1:0]          sum;
    logic signed [EW-1:0]          sig;
    logic signed [ACC_WIDTH-1:0]   relu_v;
    logic                          wr_en;

    function automatic logic [DATA_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] v);
        if (v > OUT_MAX)      return OUT_MAX[DATA_WIDTH-1:0];
        else if (v < OUT_MIN) return OUT_MIN[DATA_WIDTH-1:0];
        else                  return v[DATA_WIDTH-1:0];
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    state_q <= S_IDLE;
        else if (En) state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (Run) state_d = S_LOAD;
            S_LOAD:   state_d = S_MAC;
            S_MAC:    if (idx_q == AW'(NUM_INPUTS-1)) state_d = S_ACT;
            S_ACT:    state_d = S_RESULT;
            S_RESULT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        Busy  = (state_q != S_IDLE);
        Ready = ready_q;
        Y     = y_q;
    end

    // Weight/bias file; addresses above NUM_INPUTS match no entry and are dropped.
    assign wr_en = En && w_we && (state_q == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= NUM_INPUTS; i++) w_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i <= NUM_INPUTS; i++)
                if (w_addr == AW'(i)) w_q[i] <= w_data;
        end
    end

    // Saturating accumulate of the Q-aligned product
    always_comb begin
        prod  = xr_q[idx_q] * w_q[idx_q];
        sum   = SW'(acc_q) + SW'(prod >>> FRAC_BITS);
        acc_d = sum[ACC_WIDTH-1:0];
        if (sum > ACC_MAX)      acc_d = ACC_MAX[ACC_WIDTH-1:0];
        else if (sum < ACC_MIN) acc_d = ACC_MIN[ACC_WIDTH-1:0];
    end

    always_comb begin
        sig    = (EW'(acc_q) >>> 2) + HALF;
        relu_v = acc_q[ACC_WIDTH-1] ? '0 : acc_q;
        act_d  = '0;
        case (mode_q)
            2'b01:   act_d = sat_out(relu_v);
            2'b10:   act_d = sat_out(acc_q);
            default: begin
                if (sig[EW-1])      act_d = '0;
                else if (sig > ONE) act_d = ONE[DATA_WIDTH-1:0];
                else                act_d = sig[DATA_WIDTH-1:0];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) xr_q[i] <= '0;
            mode_q  <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            yb_q    <= '0;
            y_q     <= '0;
            ready_q <= 1'b0;
        end else if (En) begin
            case (state_q)
                S_IDLE: ready_q <= 1'b0;
                S_LOAD: begin
                    for (int i = 0; i < NUM_INPUTS; i++)
                        xr_q[i] <= X[i*DATA_WIDTH +: DATA_WIDTH];
                    mode_q <= Mode;
                    acc_q  <= ACC_WIDTH'(w_q[NUM_INPUTS]);
                    idx_q  <= '0;
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + AW'(1);
                end
                S_ACT: yb_q <= act_d;
                S_RESULT: begin
                    y_q     <= yb_q;
                    ready_q <= 1'b1;
                end
                default: ready_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_n.sv
// Self-checking bench for neuron_mac_n: a behavioural scoreboard predicts Ready timing, Busy and Y
// every cycle, and directed runs pin the model with hand-computed results.
module tb_neuron_mac_n;

    localparam int NI   = 2;
    localparam int DW   = 8;
    localparam int F    = 4;
    localparam int ACCW = 2*DW;
    localparam int AWT  = $clog2(NI+1);

    logic               clk = 1'b0;
    logic               rst;
    logic               En;
    logic               Run;
    logic [1:0]         Mode;
    logic [NI*DW-1:0]   X;
    logic               w_we;
    logic [AWT-1:0]     w_addr;
    logic [DW-1:0]      w_data;
    logic [DW-1:0]      Y;
    logic               Ready;
    logic               Busy;

    neuron_mac_n #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .FRAC_BITS(F), .ACC_WIDTH(ACCW), .AW(AWT)) dut (
        .clk(clk), .rst(rst), .En(En), .Run(Run), .Mode(Mode), .X(X),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .Y(Y), .Ready(Ready), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct { int start; int rdy; int y; } exp_t;
    exp_t q[$];

    int cyc = 0;
    int y_hold = 0;
    int n_chk = 0;
    int n_pass = 0;
    int wm [0:NI];
    int xin [0:NI-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    // Reference neuron computed from the arithmetic rules with wide integers.
    function automatic int model_y(input logic [1:0] md);
        longint amax = (longint'(1) <<< (ACCW-1)) - 1;
        longint amin = -amax - 1;
        longint omax = (longint'(1) <<< (DW-1)) - 1;
        longint omin = -omax - 1;
        longint one  = longint'(1) <<< F;
        longint acc  = wm[NI];
        longint r;
        for (int i = 0; i < NI; i++) begin
            acc = acc + ((longint'(xin[i]) * longint'(wm[i])) >>> F);
            if (acc > amax) acc = amax;
            if (acc < amin) acc = amin;
        end
        case (md)
            2'b01: begin
                r = (acc < 0) ? 0 : acc;
                if (r > omax) r = omax;
            end
            2'b10: begin
                r = acc;
                if (r > omax) r = omax;
                if (r < omin) r = omin;
            end
            default: begin
                r = one/2 + (acc >>> 2);
                if (r < 0) r = 0;
                if (r > one) r = one;
            end
        endcase
        return int'(r);
    endfunction

    // Per-cycle compare against the scoreboard
    always @(negedge clk) begin
        bit exp_r;
        int bexp;
        exp_r = (q.size() > 0) && (q[0].rdy == cyc);
        chk("ready", int'(Ready), int'(exp_r));
        if (exp_r) begin
            chk("y_on_ready", int'($signed(Y)), q[0].y);
            y_hold = q[0].y;
            void'(q.pop_front());
        end else begin
            chk("y_hold", int'($signed(Y)), y_hold);
        end
        bexp = 0;
        foreach (q[k]) if (cyc >= q[k].start && cyc < q[k].rdy) bexp = 1;
        chk("busy", int'(Busy), bexp);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_x();
        for (int i = 0; i < NI; i++) X[i*DW +: DW] = DW'(xin[i]);
    endtask

    task automatic write_w(input int a, input int d);
        w_we = 1'b1; w_addr = AWT'(a); w_data = DW'(d);
        tick();
        w_we = 1'b0;
        if (a <= NI) wm[a] = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        y_hold = 0;
        for (int i = 0; i <= NI; i++) wm[i] = 0;
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (q.size() > 0 && n < 200) begin tick(); n++; end
        if (q.size() > 0) begin
            chk("ready_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic run_one(input logic [1:0] md, input int stall, input bit do_w, input int wa,
                           input int wd, input bit use_lit, input int lit);
        int e0;
        if (do_w) begin
            w_we = 1'b1; w_addr = AWT'(wa); w_data = DW'(wd);
            if (wa <= NI) wm[wa] = wd;
        end
        Mode = md; pack_x(); Run = 1'b1; En = 1'b1;
        e0 = cyc + 1;
        q.push_back('{start: e0, rdy: e0 + NI + 3 + stall, y: model_y(md)});
        tick();
        Run = 1'b0; w_we = 1'b0;
        tick();
        X = NI*DW'($urandom); Mode = 2'($urandom_range(3));
        if (stall > 0) begin
            En = 1'b0;
            repeat (stall) tick();
            En = 1'b1;
        end
        Run = 1'b1; w_we = 1'b1; w_addr = AWT'($urandom_range(NI)); w_data = DW'($urandom);
        tick();
        Run = 1'b0; w_we = 1'b0;
        wait_empty();
        if (use_lit) chk("y_literal", int'($signed(Y)), lit);
        $display("run mode=%0d x0=%0d x1=%0d stall=%0d -> Y=%0d", md, xin[0], xin[NI-1], stall, $signed(Y));
    endtask

    initial begin
        int e0, yexp;
        rst = 1'b0; En = 1'b1; Run = 1'b0; Mode = 2'b00; X = '0;
        w_we = 1'b0; w_addr = '0; w_data = '0;
        for (int i = 0; i <= NI; i++) wm[i] = 0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Weights -66, 64, bias -45; out-of-range address must be dropped
        write_w(0, -66); write_w(1, 64); write_w(NI, -45); write_w(3, 99);
        xin[0] = 16; xin[1] = 0;  run_one(2'b00, 0, 0, 0, 0, 1, 0);
        xin[0] = 0;  xin[1] = 16; run_one(2'b00, 0, 0, 0, 0, 1, 12);
        xin[0] = 16; xin[1] = 0;  run_one(2'b01, 0, 0, 0, 0, 1, 0);
        xin[0] = 16; xin[1] = 0;  run_one(2'b10, 0, 0, 0, 0, 1, -111);
        xin[0] = 0;  xin[1] = 16; run_one(2'b00, 3, 0, 0, 0, 1, 12);

        // Saturation; W1 written in the same cycle as the Run accept
        write_w(0, 127); write_w(NI, 0);
        xin[0] = 127;  xin[1] = 127;  run_one(2'b10, 0, 1, 1, 127, 1, 127);
        xin[0] = -127; xin[1] = -127; run_one(2'b10, 0, 0, 0, 0, 1, -128);

        // Back-to-back with Run held high
        write_w(0, -66); write_w(1, 64); write_w(NI, -45);
        xin[0] = 0; xin[1] = 16; pack_x(); Mode = 2'b00; Run = 1'b1;
        e0 = cyc + 1;
        yexp = model_y(2'b00);
        q.push_back('{start: e0, rdy: e0 + NI + 3, y: yexp});
        q.push_back('{start: e0 + NI + 4, rdy: e0 + 2*NI + 7, y: yexp});
        repeat (NI + 5) tick();
        Run = 1'b0;
        tick();
        X = '0;
        wait_empty();
        chk("b2b_y_literal", int'($signed(Y)), 12);
        $display("back-to-back runs -> Y=%0d", $signed(Y));

        // Reset mid-MAC, then a run must see zeroed weights
        xin[0] = 16; xin[1] = 16; pack_x(); Mode = 2'b00; Run = 1'b1;
        e0 = cyc + 1;
        q.push_back('{start: e0, rdy: e0 + NI + 3, y: model_y(2'b00)});
        tick(); Run = 1'b0;
        tick(); tick();
        do_reset();
        $display("reset mid-MAC -> Busy=%0d Ready=%0d Y=%0d", Busy, Ready, $signed(Y));
        run_one(2'b00, 0, 0, 0, 0, 1, 8);

        // Mixed runs checked by the model only
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i <= NI; i++) write_w(i, int'($urandom_range(255)) - 128);
            for (int i = 0; i < NI; i++) xin[i] = int'($urandom_range(255)) - 128;
            run_one(2'($urandom_range(3)), int'($urandom_range(2)), 0, 0, 0, 0, 0);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
